// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: write/read handshake, data, status and error-flag bundle for sync_fifo_ctrl.
// The master modport is the FIFO user side and the slave modport is the FIFO.
interface sync_fifo_ctrl_if #(
  parameter int word_size = 8,
  parameter int ptr_size  = 4
);
  logic                 write_en;
  logic [word_size-1:0] write_data_in;
  logic                 read_en;
  logic [word_size-1:0] read_data_out;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ptr_size:0]    level;
  logic                 overflow;
  logic                 underflow;
  logic                 clr_err;

  modport master (
    output write_en, write_data_in, read_en, clr_err,
    input  read_data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  write_en, write_data_in, read_en, clr_err,
    output read_data_out, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with register-array storage, level/threshold flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; otherwise read data is registered.
module sync_fifo_ctrl #(
  parameter int word_size = 8,
  parameter int ptr_size  = 4,
  parameter int af_level  = 14,
  parameter int ae_level  = 2
) (
  input logic             clk,
  input logic             reset,
  sync_fifo_ctrl_if.slave bus
);
  localparam int depth = 1 << ptr_size;
  localparam logic [ptr_size:0] af_thresh = af_level[ptr_size:0];
  localparam logic [ptr_size:0] ae_thresh = ae_level[ptr_size:0];
  localparam logic [ptr_size:0] ptr_one   = 1;

  logic [ptr_size:0]    b_write_ptr;
  logic [ptr_size:0]    b_read_ptr;
  logic [ptr_size-1:0]  wr_addr;
  logic [ptr_size-1:0]  rd_addr;
  logic [word_size-1:0] mem [depth];
  logic [ptr_size:0]    level_int;
  logic                 full_int;
  logic                 empty_int;
  logic                 wr_accept;
  logic                 rd_accept;
  logic                 wr_reject;
  logic                 rd_reject;
  logic                 overflow_q;
  logic                 underflow_q;
  logic [word_size-1:0] read_data;

  assign wr_addr   = b_write_ptr[ptr_size-1:0];
  assign rd_addr   = b_read_ptr[ptr_size-1:0];

  // Wrap bits differ with equal addresses means the writer is a full lap ahead.
  assign full_int  = (b_write_ptr[ptr_size] != b_read_ptr[ptr_size]) && (wr_addr == rd_addr);
  assign empty_int = (b_write_ptr == b_read_ptr);
  assign level_int = b_write_ptr - b_read_ptr;

  assign wr_accept = bus.write_en && !full_int;
  assign rd_accept = bus.read_en && !empty_int;
  assign wr_reject = bus.write_en && full_int;
  assign rd_reject = bus.read_en && empty_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_write_ptr <= '0;
      b_read_ptr  <= '0;
    end else begin
      if (wr_accept) b_write_ptr <= b_write_ptr + ptr_one;
      if (rd_accept) b_read_ptr  <= b_read_ptr + ptr_one;
    end
  end

  // Storage is deliberately left out of reset; contents are only observable behind a valid pointer.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr] <= bus.write_data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_reject)        overflow_q <= 1'b1;
      else if (bus.clr_err) overflow_q <= 1'b0;
      if (rd_reject)        underflow_q <= 1'b1;
      else if (bus.clr_err) underflow_q <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign read_data = empty_int ? '0 : mem[rd_addr];
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          read_data <= '0;
    else if (rd_accept) read_data <= mem[rd_addr];
  end
`endif

  assign bus.read_data_out = read_data;
  assign bus.full          = full_int;
  assign bus.empty         = empty_int;
  assign bus.level         = level_int;
  assign bus.almost_full   = (level_int >= af_thresh);
  assign bus.almost_empty  = (level_int <= ae_thresh);
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: randomized and directed checks of sync_fifo_ctrl against a queue-based FIFO model.
// Build with SYNC_FIFO_FWFT_EN defined to exercise the first-word-fall-through read path.
module tb_sync_fifo_ctrl;
  localparam int word_size = 8;
  localparam int ptr_size  = 4;
  localparam int depth     = 16;
  localparam int af_level  = 14;
  localparam int ae_level  = 2;

  logic clk = 1'b0;
  logic reset;

  sync_fifo_ctrl_if #(.word_size(word_size), .ptr_size(ptr_size)) bus ();

  sync_fifo_ctrl #(
    .word_size(word_size), .ptr_size(ptr_size), .af_level(af_level), .ae_level(ae_level)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q [$];
  logic       ovf_m;
  logic       udf_m;
  logic [7:0] rdata_m;

  function automatic logic [7:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() == 0) ? 8'h00 : q[0];
`else
    return rdata_m;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    ovf_m   = 1'b0;
    udf_m   = 1'b0;
    rdata_m = 8'h00;
  endtask

  // Applies one clock edge to the queue model, judging both accesses against the pre-edge occupancy.
  task automatic model_edge(input logic we, input logic [7:0] wd, input logic re, input logic ce);
    bit was_full  = (q.size() == depth);
    bit was_empty = (q.size() == 0);
    if (re && !was_empty) rdata_m = q.pop_front();
    if (we && !was_full) q.push_back(wd);
    ovf_m = (we && was_full)  ? 1'b1 : (ce ? 1'b0 : ovf_m);
    udf_m = (re && was_empty) ? 1'b1 : (ce ? 1'b0 : udf_m);
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic ce);
    bus.write_en      = we;
    bus.write_data_in = wd;
    bus.read_en       = re;
    bus.clr_err       = ce;
    @(posedge clk);
    model_edge(we, wd, re, ce);
    #1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.clr_err  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.write_en = 1'b0; bus.write_data_in = '0; bus.read_en = 1'b0; bus.clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.almost_full !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0 ||
        bus.read_data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got level=%0d e=%b ae=%b f=%b af=%b ovf=%b udf=%b dout=%h, want 0 1 1 0 0 0 0 00",
               bus.level, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
               bus.overflow, bus.underflow, bus.read_data_out);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: got empty=%b level=%0d, want 1 0", bus.empty, bus.level);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= depth; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (bus.level !== 5'(i) || bus.almost_full !== (i >= af_level) || bus.full !== (i == depth) ||
          bus.almost_empty !== (i <= ae_level) || bus.empty !== 1'b0) begin
        errors++;
        $display("FAIL fill[%0d]: got level=%0d af=%b f=%b ae=%b e=%b, want %0d %b %b %b 0", i,
                 bus.level, bus.almost_full, bus.full, bus.almost_empty, bus.empty,
                 i, (i >= af_level), (i == depth), (i <= ae_level));
      end
    end
  endtask

  task automatic test_overflow_drain();
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.level !== 5'd16 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got ovf=%b level=%0d full=%b, want 1 16 1",
               bus.overflow, bus.level, bus.full);
    end
    for (int i = 1; i <= depth; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      checks++;
      if (bus.read_data_out !== 8'(i)) begin
        errors++;
        $display("FAIL drain_head[%0d]: got %h, want %h", i, bus.read_data_out, 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
`else
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (bus.read_data_out !== 8'(i)) begin
        errors++;
        $display("FAIL drain_data[%0d]: got %h, want %h", i, bus.read_data_out, 8'(i));
      end
`endif
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.level !== 5'd0 || bus.overflow !== 1'b1 || bus.read_data_out !== exp_dout()) begin
      errors++;
      $display("FAIL drain_end: got empty=%b level=%0d ovf=%b dout=%h, want 1 0 1 %h",
               bus.empty, bus.level, bus.overflow, bus.read_data_out, exp_dout());
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.underflow !== 1'b1 || bus.read_data_out !== exp_dout() || bus.level !== 5'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set: got udf=%b dout=%h level=%0d empty=%b, want 1 %h 0 1",
               bus.underflow, bus.read_data_out, bus.level, bus.empty, exp_dout());
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: got udf=%b ovf=%b, want 0 0", bus.underflow, bus.overflow);
    end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (bus.underflow !== 1'b1 || bus.underflow !== udf_m) begin
      errors++;
      $display("FAIL clr_vs_set: got udf=%b, want 1", bus.underflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int lv;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 8'(8'h85 + c), 1'b1, 1'b0);
      lv = q.size();
      checks++;
      if (bus.level !== 5'd5 || lv != 5 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0 ||
          bus.full !== 1'b0 || bus.empty !== 1'b0 || bus.read_data_out !== exp_dout()) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got level=%0d ovf=%b udf=%b f=%b e=%b dout=%h, want 5 0 0 0 0 %h",
                 c, bus.level, bus.overflow, bus.underflow, bus.full, bus.empty,
                 bus.read_data_out, exp_dout());
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    checks++;
    if (bus.level !== 5'd7) begin
      errors++;
      $display("FAIL async_pre_level: got %0d, want 7", bus.level);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.almost_full !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0 ||
        bus.read_data_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got level=%0d e=%b ae=%b f=%b af=%b ovf=%b udf=%b dout=%h, want 0 1 1 0 0 0 0 00",
               bus.level, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
               bus.overflow, bus.underflow, bus.read_data_out);
    end
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    checks++;
    if (bus.level !== 5'd1 || bus.read_data_out !== exp_dout()) begin
      errors++;
      $display("FAIL post_reset_write: got level=%0d dout=%h, want 1 %h", bus.level, bus.read_data_out, exp_dout());
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (bus.read_data_out !== 8'h00 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_read: got dout=%h empty=%b, want 00 1", bus.read_data_out, bus.empty);
    end
`else
    checks++;
    if (bus.read_data_out !== 8'h5A || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_read: got dout=%h empty=%b, want 5a 1", bus.read_data_out, bus.empty);
    end
`endif
  endtask

  task automatic test_random();
    int wprob;
    int lv;
    logic we, re, ce;
    for (int c = 0; c < 450; c++) begin
      wprob = (c < 150) ? 75 : ((c < 300) ? 25 : 50);
      we = ($urandom_range(0, 99) < wprob);
      re = ($urandom_range(0, 99) < (100 - wprob));
      ce = ($urandom_range(0, 99) < 5);
      step(we, 8'($urandom), re, ce);
      lv = q.size();
      checks++;
      if (bus.level !== 5'(lv) || bus.full !== (lv == depth) || bus.empty !== (lv == 0) ||
          bus.almost_full !== (lv >= af_level) || bus.almost_empty !== (lv <= ae_level) ||
          bus.overflow !== ovf_m || bus.underflow !== udf_m || bus.read_data_out !== exp_dout()) begin
        errors++;
        $display("FAIL random[%0d]: got level=%0d f=%b e=%b af=%b ae=%b ovf=%b udf=%b dout=%h, want %0d %b %b %b %b %b %b %h",
                 c, bus.level, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                 bus.overflow, bus.underflow, bus.read_data_out,
                 lv, (lv == depth), (lv == 0), (lv >= af_level), (lv <= ae_level),
                 ovf_m, udf_m, exp_dout());
      end
    end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    checks++;
    if (bus.empty !== 1'b0 || bus.read_data_out !== 8'h3C) begin
      errors++;
      $display("FAIL fwft_head: got empty=%b dout=%h, want 0 3c", bus.empty, bus.read_data_out);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.empty !== 1'b1 || bus.read_data_out !== 8'h00) begin
      errors++;
      $display("FAIL fwft_pop: got empty=%b dout=%h, want 1 00", bus.empty, bus.read_data_out);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
